// File: rtl/add_result_fifo.sv
// Result FIFO between an 8-bit adder and its consumer; stores {cout, sum}.
// Optional carry statistics ports enabled by ADD_RESULT_FIFO_CARRY_STATS_EN.
module add_result_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_sum,
   input  logic       in_cout,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [8:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [4:0] count
`ifdef ADD_RESULT_FIFO_CARRY_STATS_EN
   ,
   output logic       carry_seen,
   output logic [7:0] carry_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [4:0] FULL = 5'(DEPTH);

   logic [8:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [4:0]    cnt_q, cnt_d;
   logic          push, pop;

   // Flags come only from the registered count, never from out_ready.
   assign in_ready  = (cnt_q != FULL);
   assign out_valid = (cnt_q != 5'd0);
   assign out_data  = mem_q[rd_q];
   assign count     = cnt_q;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 5'd1;
         2'b01:   cnt_d = cnt_q - 5'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {in_cout, in_sum};
   end

`ifdef ADD_RESULT_FIFO_CARRY_STATS_EN
   logic       seen_q, seen_d;
   logic [7:0] ccnt_q, ccnt_d;
   logic       cpush;

   assign cpush = push && in_cout;

   always_comb begin
      seen_d = seen_q | cpush;
      ccnt_d = ccnt_q;
      if (cpush && (ccnt_q != 8'hFF)) ccnt_d = ccnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seen_q <= 1'b0;
         ccnt_q <= 8'd0;
      end else begin
         seen_q <= seen_d;
         ccnt_q <= ccnt_d;
      end
   end

   assign carry_seen = seen_q;
   assign carry_cnt  = ccnt_q;
`endif

endmodule
